display_update_arbiter: RTL and testbench
=========================================

Name: display_update_arbiter

Overview:
- Sits between the elevator controller logic and the VGA pixel generator.
- Arbitrates two requesters that push display-state updates (sim_state, destination, people_data) into one shared staging buffer:
  - requester 0: elevator FSM
  - requester 1: override/debug source
- Copies the staging buffer to the pixel generator's inputs only at vertical-blank start, so frames never tear.
- Also reports frame ticks and counts lost updates.

Parameters:
- H_TOTAL, 800, pixels per line including blanking; horiz_count runs 0..H_TOTAL-1
- V_ACTIVE, 480, visible lines; vblank starts at vert_count == V_ACTIVE
- STATE_W, 3, width of sim_state
- DEST_W, 3, width of destination
- PEOPLE_W, 8, width of people_data
- DROP_W, 8, width of dropped-update counter

Ports:
- pixel_clk  in  1  pixel clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- horiz_count  in  10  current horizontal pixel counter
- vert_count  in  10  current vertical line counter
- req  in  2  per-requester update request, level, held until acked
- state_in0 / state_in1  in  STATE_W each  requester sim_state payload
- dest_in0 / dest_in1  in  DEST_W each  requester destination payload
- people_in0 / people_in1  in  PEOPLE_W each  requester people payload
- ack  out  2  one-cycle grant/accept pulse per requester
- sim_state  out  STATE_W  committed value to pixel generator
- destination  out  DEST_W  committed value
- people_data  out  PEOPLE_W  committed value
- frame_tick  out  1  one-cycle pulse at each commit point
- pending  out  1  staging buffer holds uncommitted data
- dropped_updates  out  DROP_W  saturating count of staging overwrites

Behaviour:
- Reset (async, any time): clears all state. Until the first commit after reset:
  - outputs: ack=0, sim_state=0, destination=0, people_data=0, frame_tick=0, pending=0, dropped_updates=0
  - internal: staging=0, rr pointer=0, both holdoff flags=0
- Eligibility: requester i is eligible when req[i]=1 and holdoff[i]=0.
  - holdoff[i] is set on the cycle ack[i] is high and clears one cycle later.
  - Effect: a requester holding req high is accepted at most every 2nd cycle.
- Arbitration and staging write, at a rising edge:
  - One eligible requester: that requester is granted.
  - Both eligible: the requester equal to the rr pointer is granted, then the pointer flips to the other index.
  - A single-requester grant sets the pointer to the other index.
  - On grant: ack[g] goes high for exactly the following cycle, and the staging buffer captures that requester's payload at the same edge.
  - Latency: req sampled high at edge N gives ack high in cycle N..N+1 and data staged at edge N.
- Drop counting: a grant while pending=1 (and not coinciding with a commit) overwrites the staging buffer. dropped_updates then increments and saturates at 2^DROP_W-1.
- Commit point: the cycle where vert_count==V_ACTIVE and horiz_count==0, evaluated on inputs.
  - At that edge, frame_tick pulses high for the next cycle.
  - If pending=1: sim_state/destination/people_data take the staging contents as they were before this edge, and pending clears.
  - If pending=0: outputs hold their values.
- Commit and grant on the same edge:
  - Commit uses the old staging contents.
  - The new payload enters staging, and pending stays 1; the new data is shown next frame.
  - No drop is counted.
- Outputs change only at commit points (or reset). ack is never high for both bits in the same cycle.
- Commit detection uses equality only. If counters skip the point (e.g. reset released mid-frame), the next frame's point is used. No commit is emitted twice for one frame, because horiz_count advances each cycle.
- pending is set by any grant and cleared by a commit without a coincident grant.
- No combinational path from req to ack: ack is registered.

Test Plan:
- Reset mid-frame with pending=1 and staging=5: after release, all outputs 0, pending=0, no ack; the next commit leaves outputs at 0.
- Single update: req[0] with state_in0=3, dest_in0=2, people_in0=7 at vert_count=100.
  - Required: ack[0] 1-cycle pulse, pending=1, outputs unchanged until (480,0).
  - Then frame_tick pulses and outputs read 3/2/7.
- Simultaneous requests:
  - Both req bits held high from reset: acks alternate 0,1,0,1 on every other cycle each, never overlapping.
  - dropped_updates increments on every grant after the first until commit.
- Saturation: 300 overwriting grants within one frame leave dropped_updates=255.
- Commit collision: grant from req[1] (people=9) on the exact commit edge while staging holds people=4.
  - Outputs show 4 this frame; pending remains 1.
  - At the next frame's commit, outputs show 9.
- Idle frames: no requests for 3 frames gives exactly 3 frame_tick pulses, with outputs and pending unchanged.

Source files
------------

// File: rtl/display_update_arbiter.sv
// Arbitrates two display-update requesters into one staging buffer and commits
// it to the pixel generator at vertical-blank start so frames never tear.
module display_update_arbiter #(
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned STATE_W  = 3,
    parameter int unsigned DEST_W   = 3,
    parameter int unsigned PEOPLE_W = 8,
    parameter int unsigned DROP_W   = 8
) (
    input  logic                pixel_clk,
    input  logic                reset,
    input  logic [9:0]          horiz_count,
    input  logic [9:0]          vert_count,
    input  logic [1:0]          req,
    input  logic [STATE_W-1:0]  state_in0,
    input  logic [STATE_W-1:0]  state_in1,
    input  logic [DEST_W-1:0]   dest_in0,
    input  logic [DEST_W-1:0]   dest_in1,
    input  logic [PEOPLE_W-1:0] people_in0,
    input  logic [PEOPLE_W-1:0] people_in1,
    output logic [1:0]          ack,
    output logic [STATE_W-1:0]  sim_state,
    output logic [DEST_W-1:0]   destination,
    output logic [PEOPLE_W-1:0] people_data,
    output logic                frame_tick,
    output logic                pending,
    output logic [DROP_W-1:0]   dropped_updates
);

    typedef struct packed {
        logic [STATE_W-1:0]  sim_state;
        logic [DEST_W-1:0]   destination;
        logic [PEOPLE_W-1:0] people_data;
    } payload_t;

    localparam logic [9:0] COMMIT_LINE = 10'(V_ACTIVE);

    payload_t   payload0;
    payload_t   payload1;
    payload_t   grant_payload;
    payload_t   staging;
    payload_t   shown;

    logic [1:0] holdoff;
    logic [1:0] eligible;
    logic [1:0] grant_onehot;
    logic       rr_ptr;
    logic       grant_valid;
    logic       grant_idx;
    logic       line_in_range;
    logic       commit_point;
    logic       overwrite;

    assign payload0      = {state_in0, dest_in0, people_in0};
    assign payload1      = {state_in1, dest_in1, people_in1};
    assign grant_payload = grant_idx ? payload1 : payload0;

    // Counter values past the end of a line never qualify as a commit point.
    assign line_in_range = 32'(horiz_count) < H_TOTAL;
    assign commit_point  = line_in_range && (vert_count == COMMIT_LINE) && (horiz_count == '0);

    // A grant onto uncommitted data loses it, unless a commit drains it first.
    assign overwrite     = grant_valid && pending && !commit_point;
    assign grant_onehot  = {grant_valid & grant_idx, grant_valid & ~grant_idx};

    always_comb begin
        // NOTE: defaults assigned first so every path drives every signal; no latches.
        eligible    = req & ~holdoff;
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        unique case (eligible)
            2'b01: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b0;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b1;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_idx   = rr_ptr;
            end
            default: begin
                grant_valid = 1'b0;
                grant_idx   = 1'b0;
            end
        endcase
    end

    // NOTE: every register is cleared by the asynchronous reset; there is no storage array here.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            ack             <= '0;
            holdoff         <= '0;
            rr_ptr          <= 1'b0;
            staging         <= '0;
            shown           <= '0;
            frame_tick      <= 1'b0;
            pending         <= 1'b0;
            dropped_updates <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            ack        <= grant_onehot;
            holdoff    <= grant_onehot;
            frame_tick <= commit_point;

            if (grant_valid) begin
                rr_ptr  <= ~grant_idx;
                staging <= grant_payload;
            end

            // The commit reads staging as it was before this edge.
            if (commit_point && pending) begin
                shown <= staging;
            end

            if (grant_valid) begin
                pending <= 1'b1;
            end else if (commit_point) begin
                pending <= 1'b0;
            end

            if (overwrite && (dropped_updates != '1)) begin
                dropped_updates <= dropped_updates + DROP_W'(1);
            end
        end
    end

    assign sim_state   = shown.sim_state;
    assign destination = shown.destination;
    assign people_data = shown.people_data;

endmodule

// File: tb/tb_display_update_arbiter.sv
// Self-checking bench for display_update_arbiter: directed vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_display_update_arbiter;

    logic       pixel_clk = 1'b0;
    logic       reset;
    logic [9:0] horiz_count;
    logic [9:0] vert_count;
    logic [1:0] req;
    logic [2:0] state_in0, state_in1, dest_in0, dest_in1;
    logic [7:0] people_in0, people_in1;
    logic [1:0] ack;
    logic [2:0] sim_state, destination;
    logic [7:0] people_data;
    logic       frame_tick;
    logic       pending;
    logic [7:0] dropped_updates;

    int checks = 0;
    int errors = 0;

    display_update_arbiter dut (
        .pixel_clk      (pixel_clk),
        .reset          (reset),
        .horiz_count    (horiz_count),
        .vert_count     (vert_count),
        .req            (req),
        .state_in0      (state_in0),
        .state_in1      (state_in1),
        .dest_in0       (dest_in0),
        .dest_in1       (dest_in1),
        .people_in0     (people_in0),
        .people_in1     (people_in1),
        .ack            (ack),
        .sim_state      (sim_state),
        .destination    (destination),
        .people_data    (people_data),
        .frame_tick     (frame_tick),
        .pending        (pending),
        .dropped_updates(dropped_updates)
    );

    always #5 pixel_clk = ~pixel_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] e_ack, input logic e_tick,
                                 input logic e_pend, input logic [2:0] e_s, input logic [2:0] e_d,
                                 input logic [7:0] e_p, input logic [7:0] e_drop);
        check({tag, " ack"}, ack, e_ack);
        check({tag, " frame_tick"}, frame_tick, e_tick);
        check({tag, " pending"}, pending, e_pend);
        check({tag, " sim_state"}, sim_state, e_s);
        check({tag, " destination"}, destination, e_d);
        check({tag, " people_data"}, people_data, e_p);
        check({tag, " dropped"}, dropped_updates, e_drop);
    endtask

    // ---------------- reference model ----------------
    // Acceptance is timestamp based: a requester may be granted again only
    // two or more edges after its previous grant.
    int m_edge, m_rr, m_pend, m_tick, m_ack, m_drop;
    int m_last[2];
    int m_stage[3];
    int m_out[3];

    task automatic model_reset();
        m_edge = 0; m_rr = 0; m_pend = 0; m_tick = 0; m_ack = 0; m_drop = 0;
        m_last[0] = -100; m_last[1] = -100;
        for (int k = 0; k < 3; k++) begin
            m_stage[k] = 0;
            m_out[k]   = 0;
        end
    endtask

    task automatic model_step();
        bit commit;
        bit e0, e1;
        int g;
        commit = (vert_count == 10'd480) && (horiz_count == 10'd0);
        e0 = req[0] && (m_edge - m_last[0] >= 2);
        e1 = req[1] && (m_edge - m_last[1] >= 2);
        g = -1;
        if (e0 && e1) g = m_rr;
        else if (e0) g = 0;
        else if (e1) g = 1;

        if (g >= 0 && m_pend == 1 && !commit && m_drop < 255) m_drop++;
        if (commit && m_pend == 1) m_out = m_stage;
        m_tick = commit;
        m_ack  = 0;
        if (g >= 0) begin
            if (g == 0) m_stage = '{int'(state_in0), int'(dest_in0), int'(people_in0)};
            else        m_stage = '{int'(state_in1), int'(dest_in1), int'(people_in1)};
            m_pend    = 1;
            m_ack     = 1 << g;
            m_last[g] = m_edge;
            m_rr      = 1 - g;
        end else if (commit) begin
            m_pend = 0;
        end
        m_edge++;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0] req;
        logic [2:0] s0, d0;
        logic [7:0] p0;
        logic [2:0] s1, d1;
        logic [7:0] p1;
        logic [9:0] vert, horiz;
        logic [1:0] e_ack;
        logic       e_tick, e_pend;
        logic [2:0] e_s, e_d;
        logic [7:0] e_p, e_drop;
    } vec_t;

    vec_t tbl[12];

    task automatic sweep_frame(output int ticks);
        ticks = 0;
        req = 2'b00;
        for (int v = 478; v <= 481; v++) begin
            for (int h = 0; h < 800; h++) begin
                vert_count  = 10'(v);
                horiz_count = 10'(h);
                step();
                if (frame_tick) ticks++;
            end
        end
    endtask

    initial begin
        int ticks;
        int total_ticks;
        logic [2:0] keep_s, keep_d;
        logic [7:0] keep_p;

        //            req    s0 d0 p0      s1 d1 p1       vert     horiz   ack   tk pd  os od op       drop
        tbl[0]  = '{2'b01, 3, 2, 8'd7,   0, 0, 8'd0,  10'd100, 10'd5, 2'b01, 0, 1, 0, 0, 8'd0,  8'd0};
        tbl[1]  = '{2'b00, 0, 0, 8'd0,   0, 0, 8'd0,  10'd100, 10'd6, 2'b00, 0, 1, 0, 0, 8'd0,  8'd0};
        tbl[2]  = '{2'b00, 0, 0, 8'd0,   0, 0, 8'd0,  10'd480, 10'd0, 2'b00, 1, 0, 3, 2, 8'd7,  8'd0};
        tbl[3]  = '{2'b00, 0, 0, 8'd0,   0, 0, 8'd0,  10'd480, 10'd1, 2'b00, 0, 0, 3, 2, 8'd7,  8'd0};
        tbl[4]  = '{2'b01, 1, 1, 8'd4,   0, 0, 8'd0,  10'd200, 10'd0, 2'b01, 0, 1, 3, 2, 8'd7,  8'd0};
        tbl[5]  = '{2'b10, 0, 0, 8'd0,   5, 6, 8'd9,  10'd480, 10'd0, 2'b10, 1, 1, 1, 1, 8'd4,  8'd0};
        tbl[6]  = '{2'b00, 0, 0, 8'd0,   0, 0, 8'd0,  10'd480, 10'd1, 2'b00, 0, 1, 1, 1, 8'd4,  8'd0};
        tbl[7]  = '{2'b00, 0, 0, 8'd0,   0, 0, 8'd0,  10'd480, 10'd0, 2'b00, 1, 0, 5, 6, 8'd9,  8'd0};
        tbl[8]  = '{2'b01, 2, 2, 8'd10,  0, 0, 8'd0,  10'd10,  10'd0, 2'b01, 0, 1, 5, 6, 8'd9,  8'd0};
        tbl[9]  = '{2'b10, 0, 0, 8'd0,   2, 3, 8'd11, 10'd10,  10'd1, 2'b10, 0, 1, 5, 6, 8'd9,  8'd1};
        tbl[10] = '{2'b11, 4, 5, 8'd12,  6, 7, 8'd13, 10'd10,  10'd2, 2'b01, 0, 1, 5, 6, 8'd9,  8'd2};
        tbl[11] = '{2'b00, 0, 0, 8'd0,   0, 0, 8'd0,  10'd480, 10'd0, 2'b00, 1, 0, 4, 5, 8'd12, 8'd2};

        reset = 1'b1;
        req = 2'b00;
        horiz_count = 10'd0;
        vert_count  = 10'd0;
        state_in0 = '0; state_in1 = '0; dest_in0 = '0; dest_in1 = '0;
        people_in0 = '0; people_in1 = '0;
        #1;
        check_outputs("por", 2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 8'd0);
        repeat (2) @(posedge pixel_clk);
        #2 reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            req = tbl[i].req;
            state_in0 = tbl[i].s0; dest_in0 = tbl[i].d0; people_in0 = tbl[i].p0;
            state_in1 = tbl[i].s1; dest_in1 = tbl[i].d1; people_in1 = tbl[i].p1;
            vert_count = tbl[i].vert; horiz_count = tbl[i].horiz;
            step();
            check_outputs($sformatf("vec%0d", i), tbl[i].e_ack, tbl[i].e_tick, tbl[i].e_pend,
                          tbl[i].e_s, tbl[i].e_d, tbl[i].e_p, tbl[i].e_drop);
        end

        // Reset mid-frame while staging holds 5 and pending is set.
        req = 2'b01; state_in0 = 3'd5; dest_in0 = 3'd5; people_in0 = 8'd5;
        vert_count = 10'd100; horiz_count = 10'd3;
        step();
        check("rst pre pending", pending, 1'b1);
        req = 2'b00;
        #3 reset = 1'b1;
        #1;
        check_outputs("rst async", 2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 8'd0);
        @(posedge pixel_clk);
        #4 reset = 1'b0;
        vert_count = 10'd480; horiz_count = 10'd0;
        step();
        check_outputs("rst commit", 2'b00, 1'b1, 1'b0, 3'd0, 3'd0, 8'd0, 8'd0);

        // Both requesters held high: strict alternation, drops climb and saturate.
        req = 2'b11;
        state_in0 = 3'd1; dest_in0 = 3'd2; people_in0 = 8'h11;
        state_in1 = 3'd6; dest_in1 = 3'd5; people_in1 = 8'h22;
        vert_count = 10'd10;
        for (int k = 0; k < 300; k++) begin
            horiz_count = 10'(k % 800);
            step();
            check($sformatf("alt%0d ack", k), ack, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k < 8 || k > 250)
                check($sformatf("alt%0d dropped", k), dropped_updates, (k < 255) ? k : 255);
        end
        req = 2'b00;
        horiz_count = 10'd300;
        step();
        check("sat hold dropped", dropped_updates, 8'd255);
        check("sat outputs frozen", people_data, 8'd0);

        // First sweep flushes the last staged grant (requester 1), then three idle frames.
        sweep_frame(ticks);
        check("flush ticks", ticks, 1);
        check("flush sim_state", sim_state, 3'd6);
        check("flush destination", destination, 3'd5);
        check("flush people", people_data, 8'h22);
        keep_s = sim_state; keep_d = destination; keep_p = people_data;
        total_ticks = 0;
        for (int f = 0; f < 3; f++) begin
            sweep_frame(ticks);
            total_ticks += ticks;
            check($sformatf("idle%0d pending", f), pending, 1'b0);
            check($sformatf("idle%0d people", f), people_data, keep_p);
            check($sformatf("idle%0d state", f), {sim_state, destination}, {keep_s, keep_d});
        end
        check("idle tick total", total_ticks, 3);

        // Randomized run against the reference model.
        #3 reset = 1'b1;
        model_reset();
        @(posedge pixel_clk);
        #4 reset = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            req = 2'($urandom_range(0, 3));
            state_in0 = 3'($urandom); dest_in0 = 3'($urandom); people_in0 = 8'($urandom);
            state_in1 = 3'($urandom); dest_in1 = 3'($urandom); people_in1 = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                vert_count = 10'd480; horiz_count = 10'd0;
            end else begin
                vert_count  = 10'($urandom_range(470, 524));
                horiz_count = 10'($urandom_range(0, 799));
            end
            model_step();
            step();
            check_outputs($sformatf("rnd%0d", n), 2'(m_ack), 1'(m_tick), 1'(m_pend),
                          3'(m_out[0]), 3'(m_out[1]), 8'(m_out[2]), 8'(m_drop));
            check($sformatf("rnd%0d ack overlap", n), ack == 2'b11, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
